wght_upd: RTL and testbench

WGHT_UPD -- requirements
Module: wght_upd

---
 rtl/wght_upd.sv | 107 ++++++++++
 tb/tb_wght_upd.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wght_upd.sv
// wght_upd: fixed-point weight update, w <= sat(w - sat((grad*lr) >>> FRAC)).
// Rev 1.0 - initial release.
`default_nettype none

module wght_upd #(
  parameter int               WIDTH  = 32,
  parameter int               FRAC   = 24,
  parameter logic [WIDTH-1:0] W_INIT = 32'h0100_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_grad,
  input  logic [WIDTH-1:0] i_lr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_w,
  output logic [WIDTH-1:0] o_w,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_acc_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]               state;
  logic [1:0]               nxt_state;
  logic signed [WIDTH-1:0]  grad;
  logic signed [WIDTH-1:0]  lr;
  logic [WIDTH-1:0]         prod;
  logic signed [2*WIDTH-1:0] full_prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]         prod_sat;
  logic [WIDTH:0]           diff;
  logic [WIDTH-1:0]         diff_sat;
  logic                     accept_load;
  logic                     accept_start;

  assign accept_load  = (state == ST_IDLE) && i_load;
  assign accept_start = (state == ST_IDLE) && !i_load && i_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: if (accept_start) nxt_state = ST_MULT;
      ST_MULT: nxt_state = ST_SUB;
      ST_SUB:  nxt_state = ST_DONE;
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != ST_IDLE);
    o_done    = (state == ST_DONE);
    o_acc_clr = (state == ST_DONE);
  end

  // Arithmetic shift floors; the shifted value fits WIDTH bits only when its top WIDTH+1 bits agree.
  always_comb begin
    full_prod = grad * lr;
    shifted   = full_prod >>> FRAC;
    if (shifted[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){shifted[2*WIDTH-1]}})
      prod_sat = shifted[WIDTH-1:0];
    else
      prod_sat = shifted[2*WIDTH-1] ? MIN_VAL : MAX_VAL;
  end

  always_comb begin
    diff = {o_w[WIDTH-1], o_w} - {prod[WIDTH-1], prod};
    if (diff[WIDTH] != diff[WIDTH-1])
      diff_sat = diff[WIDTH] ? MIN_VAL : MAX_VAL;
    else
      diff_sat = diff[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_w  <= W_INIT;
      grad <= '0;
      lr   <= '0;
      prod <= '0;
    end else begin
      if (accept_load) begin
        o_w <= i_w;
      end else if (accept_start) begin
        grad <= i_grad;
        lr   <= i_lr;
      end
      if (state == ST_MULT) prod <= prod_sat;
      if (state == ST_SUB)  o_w  <= diff_sat;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wght_upd.sv
// tb_wght_upd: directed stimulus with a scoreboard of expected weights checked on each o_done.
`default_nettype none

module tb_wght_upd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_grad = '0;
  logic [31:0] i_lr = '0;
  logic        i_load = 1'b0;
  logic [31:0] i_w = '0;
  logic [31:0] o_w;
  logic        o_busy;
  logic        o_done;
  logic        o_acc_clr;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int done_seen = 0;
  logic [31:0] exp_q[$];

  wght_upd #(.WIDTH(32), .FRAC(24), .W_INIT(32'h0100_0000)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_grad(i_grad), .i_lr(i_lr),
    .i_load(i_load), .i_w(i_w), .o_w(o_w), .o_busy(o_busy), .o_done(o_done),
    .o_acc_clr(o_acc_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expected weight per o_done pulse.
  always @(negedge clk) begin
    if (o_done || o_acc_clr) begin
      check("acc_clr_with_done", {31'd0, o_acc_clr}, {31'd0, o_done});
      if (o_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("w_at_done", o_w, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    i_load = 1'b1;
    i_w    = v;
    @(posedge clk); #1;
    i_load = 1'b0;
    check("load_w", o_w, v);
    check("load_busy", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic do_update(input logic [31:0] g, input logic [31:0] lr,
                           input logic [31:0] exp_w, input bit collide);
    int busy_cycles;
    @(negedge clk);
    i_start = 1'b1;
    i_grad  = g;
    i_lr    = lr;
    exp_q.push_back(exp_w);
    pushed++;
    @(posedge clk); #1;
    i_start = collide;
    i_grad  = 32'h7FFF_FFFF;
    i_lr    = 32'h7FFF_FFFF;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    busy_cycles = 0;
    while (o_busy && busy_cycles < 10) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    check("busy_cycles", busy_cycles, 32'd3);
  endtask

  initial begin
    // Asynchronous reset: outputs must settle without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_w", o_w, 32'h0100_0000);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_update(32'h0080_0000, 32'h0019_999A, 32'h00F3_3333, 1'b0);

    do_load(32'h0000_0000);
    do_update(32'h7F00_0000, 32'h7F00_0000, 32'h8000_0001, 1'b0);

    do_load(32'h8000_0001);
    do_update(32'h7F00_0000, 32'h0100_0000, 32'h8000_0000, 1'b0);

    do_load(32'h0000_0000);
    do_update(32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0001, 1'b0);

    // Load and start on the same edge: load wins, no update.
    @(negedge clk);
    i_load = 1'b1; i_start = 1'b1;
    i_w = 32'h1234_5678; i_grad = 32'h0100_0000; i_lr = 32'h0100_0000;
    @(posedge clk); #1;
    i_load = 1'b0; i_start = 1'b0;
    check("collide_w", o_w, 32'h1234_5678);
    check("collide_busy", {31'd0, o_busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("collide_hold_w", o_w, 32'h1234_5678);

    // Start held high throughout the update must be ignored.
    do_update(32'h0100_0000, 32'h0040_0000, 32'h11F4_5678, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("ignored_start_busy", {31'd0, o_busy}, 32'd0);

    // Reset during MULT discards the update.
    @(negedge clk);
    i_start = 1'b1; i_grad = 32'h0100_0000; i_lr = 32'h0100_0000;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("mid_busy", {31'd0, o_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_w", o_w, 32'h0100_0000);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_done", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("post_rst_w", o_w, 32'h0100_0000);

    // First start after reset is accepted immediately.
    do_update(32'hFF80_0000, 32'h0100_0000, 32'h0180_0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", done_seen, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
